// File: rtl/stream_output_fifo.sv
// stream_output_fifo: val/rdy circular-buffer FIFO between the adder output stream and the
// output crossbar. It holds up to DEPTH words, reports its occupancy on count, and supports
// a synchronous flush. The storage array is deliberately not reset.
//
// Optional feature: define STREAM_OUTPUT_FIFO_BYPASS_EN to enable a zero-latency
// pass-through. When enabled and the FIFO is empty, a word is handed straight to send_*
// if the downstream side is ready. That mode creates a combinational path
// recv_val/recv_msg -> send_val/send_msg.
module stream_output_fifo #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_val,
    input  logic                 send_rdy,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [BIT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 full, empty;
    logic                 bypass;
    logic                 enq, deq;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

`ifdef STREAM_OUTPUT_FIFO_BYPASS_EN
    // Empty FIFO with a ready consumer: pass the word straight through, never stored.
    assign bypass = reset && !flush && empty && recv_val && send_rdy;
`else
    assign bypass = 1'b0;
`endif

    // Handshake outputs; rdy never looks at its own side's val.
    always_comb begin
        recv_rdy = reset && !flush && !full;
        send_val = bypass || (reset && !flush && !empty);
        if (bypass) begin
            send_msg = recv_msg;
        end else if (reset && !empty) begin
            send_msg = mem[rd_ptr_q];
        end else begin
            send_msg = '0;
        end
        count = count_q;
    end

    // Bypassed words are consumed on both sides without touching the buffer.
    assign enq = recv_val && recv_rdy && !bypass;
    assign deq = send_val && send_rdy && !bypass;

    // Next-state pointers and occupancy; pointers wrap by truncation (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    // State register: synchronous active-low reset, then flush, then normal update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; enq is already low during reset and flush.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr_q] <= recv_msg;
        end
    end

endmodule

// File: tb/tb_stream_output_fifo.sv
// Testbench for stream_output_fifo: directed scenarios followed by random traffic.
// A queue-based reference model predicts handshakes, occupancy and data. Define
// STREAM_OUTPUT_FIFO_BYPASS_EN to check the bypass build.
module tb_stream_output_fifo;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  recv_msg;
    logic          recv_val;
    logic          recv_rdy;
    logic [W-1:0]  send_msg;
    logic          send_val;
    logic          send_rdy;
    logic          flush;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_q[$];

    stream_output_fifo #(
        .BIT_WIDTH (W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .flush    (flush),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor and model: inputs are stable at the falling edge, so predict the outputs,
    // compare them, then apply the transfers the next rising edge will perform.
    int           sz;
    logic         byp;
    logic         exp_rdy;
    logic         exp_val;
    logic [W-1:0] exp_msg;

    always @(negedge clk) begin
        sz  = model_q.size();
        byp = 1'b0;
`ifdef STREAM_OUTPUT_FIFO_BYPASS_EN
        byp = reset && !flush && (sz == 0) && recv_val && send_rdy;
`endif
        exp_rdy = reset && !flush && (sz != DEPTH);
        exp_val = byp || (reset && !flush && (sz != 0));
        if (byp) exp_msg = recv_msg;
        else if (reset && sz != 0) exp_msg = model_q[0];
        else exp_msg = '0;

        chk("count", 64'(count), 64'(sz));
        chk("recv_rdy", 64'(recv_rdy), 64'(exp_rdy));
        chk("send_val", 64'(send_val), 64'(exp_val));
        chk("send_msg", 64'(send_msg), 64'(exp_msg));

        if (!reset || flush) begin
            model_q.delete();
        end else if (!byp) begin
            if (exp_val && send_rdy) void'(model_q.pop_front());
            if (exp_rdy && recv_val) model_q.push_back(recv_msg);
        end
    end

    task automatic step(input logic rst_n, input logic fl, input logic rv, input logic [W-1:0] m,
                        input logic sr);
        reset    = rst_n;
        flush    = fl;
        recv_val = rv;
        recv_msg = m;
        send_rdy = sr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        flush    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Fill with send_rdy low, hold off a fifth word, then drain in order.
        step(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h33, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Two entries, then simultaneous push/pop long enough for the pointers to wrap twice.
        step(1'b1, 1'b0, 1'b1, 32'h9e, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h9f, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 32'ha0 + W'(i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Full with both sides active: pop only, then the push is taken on the next edge.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'hc0 + W'(i), 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'hc4, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hc4, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Flush at count 3 with both sides active, then a fresh word.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'hd0 + W'(i), 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hdead, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'hbeef, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Reset for one cycle at count 2; nothing stale may emerge.
        step(1'b1, 1'b0, 1'b1, 32'he0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'he1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'he2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Push into an empty FIFO with a ready consumer.
        step(1'b1, 1'b0, 1'b1, 32'h1234, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_output_fifo.md
Name: stream_output_fifo

Overview:
- Val/rdy stream buffer between the Adder's output stream and the recv side of the one-in/two-out output crossbar.
- Decouples adder throughput from Wishbone read latency: absorbs up to DEPTH results while the host has not yet read.
- Circular-buffer FIFO with occupancy count and synchronous flush. Same val/rdy semantics as the rest of the stream fabric.

Parameters:
- BIT_WIDTH, 32, width of each stream message
- DEPTH, 4, number of entries; power of two, >= 2
- CNT_WIDTH, $clog2(DEPTH)+1, width of the count output; derived, not overridden

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; state clears on an edge where reset==0
- recv_msg  input  BIT_WIDTH  incoming data from Adder o_stream_data
- recv_val  input  1  incoming valid
- recv_rdy  output  1  FIFO can accept
- send_msg  output  BIT_WIDTH  head-of-queue data to crossbar recv_msg
- send_val  output  1  head entry valid
- send_rdy  input  1  downstream accepts
- flush  input  1  synchronous discard of all entries
- count  output  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Transfer rules:
  - Enqueue when recv_val && recv_rdy at a clock edge.
  - Dequeue when send_val && send_rdy at a clock edge.
  - Neither side may depend combinationally on its own val to produce rdy.
- State:
  - wr_ptr and rd_ptr, each log2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
  - Storage array; the storage array is NOT reset.
- Reset (reset==0 at an edge): wr_ptr=0, rd_ptr=0, count=0.
  - While reset is low: recv_rdy=0, send_val=0, send_msg=0.
  - Cycle after reset deasserts: recv_rdy=1, send_val=0, count=0.
- Outputs:
  - recv_rdy = reset && !flush && (count != DEPTH). A full FIFO refuses input even if a dequeue happens in the same cycle.
  - send_val = (count != 0) && !flush.
  - send_msg = mem[rd_ptr] when count != 0, otherwise 0.
  - count is a registered output.
- Latency: a word enqueued at edge N is presented on send_msg/send_val after edge N, i.e. 1-cycle minimum latency. Throughput is 1 word/cycle in steady state.
- Count update:
  - Enqueue only: +1.
  - Dequeue only: -1.
  - Both (0 < count < DEPTH): unchanged, and both pointers advance.
- Empty: send_val=0; send_rdy is ignored and does not move rd_ptr.
- Full: count==DEPTH gives recv_rdy=0. recv_val is ignored and no write occurs.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. Data order is strictly FIFO across the wrap.
- Flush (flush==1 at an edge):
  - Pointers and count go to 0.
  - Flush takes priority over any enqueue or dequeue in the same cycle; no transfer occurs because rdy and val are forced low.
- Reset mid-operation: all queued data is discarded. No send_val pulse appears after reset until a new enqueue.
- Widths: count never exceeds DEPTH. Pointer arithmetic is truncating; no overflow or underflow is possible given the gating above.

Optional Feature:
- Macro: STREAM_OUTPUT_FIFO_BYPASS_EN
- When defined, a zero-latency pass-through applies if count==0, recv_val==1, send_rdy==1 and flush==0:
  - send_msg=recv_msg and send_val=1 combinationally.
  - The word is consumed without being written; count stays 0.
  - When count==0 and send_rdy==0, the word is enqueued normally.
  - send_val then depends combinationally on recv_val. The integrator must ensure no loop through the crossbar.
- When not defined: strict 1-cycle minimum latency as above, and no combinational path from recv_* to send_*.

Test Plan:
- Reset, then 4 back-to-back pushes of 0x11,0x22,0x33,0x44 with send_rdy=0:
  - count goes 1,2,3,4.
  - recv_rdy=0 after the 4th push.
  - A 5th push of 0x55 is held off.
  - Then send_rdy=1 drains 0x11,0x22,0x33,0x44 in order, one per cycle; count returns to 0.
- Simultaneous push/pop with count=2: push 0xA0, pop head.
  - count stays 2.
  - Repeat 10 cycles so pointers wrap twice; output sequence matches input order exactly.
- Full with simultaneous send_rdy=1 and recv_val=1:
  - One pop occurs; no push occurs that cycle; count becomes 3.
  - Next cycle the push is accepted.
- Flush at count=3 while recv_val=1 and send_rdy=1:
  - Next cycle count=0 and send_val=0; no word was transferred on either side.
  - A subsequent push of 0xBEEF appears on send_msg one cycle later.
- Reset asserted (reset=0) at count=2 for one cycle:
  - recv_rdy=0, send_val=0 during reset.
  - Afterwards count=0 and no stale data emerges.
- Bypass (macro defined), empty FIFO, send_rdy=1, push 0x1234:
  - send_val=1 with send_msg=0x1234 in the same cycle; count stays 0.
  - With the macro undefined, 0x1234 instead appears one cycle later.
